// File: rtl/lvds_sync_word_decoder.sv
// lvds_sync_word_decoder
//   Multi-lane word aligner and sync decoder that sits between the IO deserialiser
//   and the line-buffer RAM. Each lane delivers serial bits LSB first. Lane 0 is
//   used to find the word boundary on a training pattern and to decode the
//   SOF/SOL/EOL/EOF sync sequences (code, 000, 000, FFF). While a line is active,
//   pixel words from all lanes pass through a 3-word delay line, so the sync
//   prefix of a closing sequence can be dropped. Each released word is written
//   one lane per cycle at a running address.
//
//   Optional feature: define LINE_LEN_CHECK_EN to count lane-0 pixels per line.
//   At EOL/EOF, a count other than LINE_LEN sets sync_err.
//
// Ports
//   clk          system clock, rising edge
//   io_rst_n     asynchronous active-low reset
//   bit_in       one serial bit per lane, sampled when bit_valid=1
//   bit_valid    bit strobe
//   relock       1-cycle pulse: drop lock and return to hunting
//   address      line-buffer write address
//   data_word    pixel word, zero-extended to OUT_W
//   write_en     1-cycle write strobe
//   locked       word alignment locked
//   frame_start  1-cycle pulse on SOF decode
//   line_end     1-cycle pulse on EOL/EOF decode
//   sync_err     sticky sync error, cleared by relock or reset
module lvds_sync_word_decoder #(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       WORD_W   = 12,
  parameter int unsigned       OUT_W    = 16,
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [WORD_W-1:0] TP       = WORD_W'(12'hA5B),
  parameter int unsigned       LOCK_CNT = 4,
  parameter logic [WORD_W-1:0] SOF_CODE = WORD_W'(12'h9D0),
  parameter logic [WORD_W-1:0] SOL_CODE = WORD_W'(12'h800),
  parameter logic [WORD_W-1:0] EOL_CODE = WORD_W'(12'hAB0),
  parameter logic [WORD_W-1:0] EOF_CODE = WORD_W'(12'hB60)
`ifdef LINE_LEN_CHECK_EN
  , parameter int unsigned     LINE_LEN = 256
`endif
) (
  input  logic              clk,
  input  logic              io_rst_n,
  input  logic [NUM_CH-1:0] bit_in,
  input  logic              bit_valid,
  input  logic              relock,
  output logic [ADDR_W-1:0] address,
  output logic [OUT_W-1:0]  data_word,
  output logic              write_en,
  output logic              locked,
  output logic              frame_start,
  output logic              line_end,
  output logic              sync_err
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [WORD_W-1:0] ZERO_W = '0;
  localparam logic [WORD_W-1:0] ONES_W = '1;
`ifdef LINE_LEN_CHECK_EN
  localparam int unsigned LC_W = $clog2(LINE_LEN + 1) + 1;
`endif

  typedef enum logic [1:0] {HUNT, LOCKING, IDLE, LINE} state_t;

  state_t                               state;
  logic [NUM_CH-1:0][WORD_W-2:0]        part;      // last WORD_W-1 bits per lane
  logic [CNT_W-1:0]                     bit_cnt;
  logic [MCH_W-1:0]                     match_cnt;
  logic [2:0][WORD_W-1:0]               hist;      // lane-0 word history, [0] newest
  logic [2:0][NUM_CH-1:0][WORD_W-1:0]   dly;       // delay line, [2] oldest
  logic [1:0]                           fill;
  logic [NUM_CH-1:0][WORD_W-1:0]        hold;      // released words awaiting write slots
  logic                                 slot_busy;
  logic [IDX_W-1:0]                     slot_idx;
`ifdef LINE_LEN_CHECK_EN
  logic [LC_W-1:0]                      line_cnt;
`endif

  logic [NUM_CH-1:0][WORD_W-1:0] word_c;
  logic                          word_done_c;
  logic                          sync_c;
  logic                          sof_c;
  logic                          sol_c;
  logic                          end_c;

  // Word assembly and sync-sequence decode on lane 0
  always_comb begin
    word_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      word_c[k] = {bit_in[k], part[k]};
    end
    word_done_c = bit_valid && (bit_cnt == CNT_W'(WORD_W - 1));
    sync_c      = word_done_c && (word_c[0] == ONES_W) &&
                  (hist[0] == ZERO_W) && (hist[1] == ZERO_W);
    sof_c       = sync_c && (hist[2] == SOF_CODE);
    sol_c       = sync_c && (hist[2] == SOL_CODE);
    end_c       = sync_c && ((hist[2] == EOL_CODE) || (hist[2] == EOF_CODE));
  end

  // Alignment FSM, delay line, write slots and outputs
  always_ff @(posedge clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state       <= HUNT;
      part        <= '0;
      bit_cnt     <= '0;
      match_cnt   <= '0;
      hist        <= '0;
      dly         <= '0;
      fill        <= '0;
      hold        <= '0;
      slot_busy   <= 1'b0;
      slot_idx    <= '0;
      address     <= '0;
      data_word   <= '0;
      write_en    <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      sync_err    <= 1'b0;
`ifdef LINE_LEN_CHECK_EN
      line_cnt    <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      write_en    <= 1'b0;

      if (bit_valid) begin
        for (int k = 0; k < NUM_CH; k++) begin
          part[k] <= word_c[k][WORD_W-1:1];
        end
        bit_cnt <= word_done_c ? '0 : bit_cnt + 1'b1;
      end
      if (word_done_c) begin
        hist <= {hist[1:0], word_c[0]};
      end

      // One lane per cycle from the hold register
      if (slot_busy) begin
        write_en  <= 1'b1;
        data_word <= OUT_W'(hold[slot_idx]);
        if (slot_idx == IDX_W'(NUM_CH - 1)) begin
          slot_busy <= 1'b0;
        end else begin
          slot_idx <= slot_idx + 1'b1;
        end
      end
      if (write_en) begin
        address <= address + 1'b1;
      end

      if (relock) begin
        state     <= HUNT;
        locked    <= 1'b0;
        sync_err  <= 1'b0;
        fill      <= '0;
        slot_busy <= 1'b0;
        write_en  <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            // Any bit position may end a training word while hunting
            if (bit_valid && (word_c[0] == TP)) begin
              bit_cnt   <= '0;
              match_cnt <= MCH_W'(1);
              if (LOCK_CNT <= 1) begin
                state  <= IDLE;
                locked <= 1'b1;
              end else begin
                state <= LOCKING;
              end
            end
          end
          LOCKING: begin
            if (word_done_c) begin
              if (word_c[0] == TP) begin
                if (match_cnt == MCH_W'(LOCK_CNT - 1)) begin
                  state  <= IDLE;
                  locked <= 1'b1;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                state <= HUNT;
              end
            end
          end
          IDLE: begin
            if (sof_c || sol_c) begin
              state       <= LINE;
              frame_start <= sof_c;
              address     <= '0;
              fill        <= '0;
`ifdef LINE_LEN_CHECK_EN
              line_cnt    <= '0;
`endif
            end
          end
          LINE: begin
            if (sof_c || sol_c) begin
              // Unexpected line start: restart the line in place
              sync_err <= 1'b1;
              address  <= '0;
              fill     <= '0;
`ifdef LINE_LEN_CHECK_EN
              line_cnt <= '0;
`endif
            end else if (end_c) begin
              // Delay line holds the code/000/000 prefix; drop it
              state    <= IDLE;
              line_end <= 1'b1;
              fill     <= '0;
`ifdef LINE_LEN_CHECK_EN
              if (line_cnt != LC_W'(LINE_LEN)) begin
                sync_err <= 1'b1;
              end
`endif
            end else if (word_done_c) begin
              dly <= {dly[1:0], word_c};
              if (fill == 2'd3) begin
                hold      <= dly[2];
                slot_busy <= 1'b1;
                slot_idx  <= '0;
`ifdef LINE_LEN_CHECK_EN
                if (line_cnt != '1) begin
                  line_cnt <= line_cnt + 1'b1;
                end
`endif
              end else begin
                fill <= fill + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_sync_word_decoder.sv
// Bench for lvds_sync_word_decoder: two instances (ADDR_W=10 and ADDR_W=4) share
// one serial stimulus. Expected writes are queued from the transmitted pixels
// (all pixels of a line, lane order, running address modulo 2^ADDR_W) and
// compared as the DUTs write them.
module tb_lvds_sync_word_decoder;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned WORD_W     = 12;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned ADDR_W_S   = 4;
  localparam int unsigned LINE_LEN_T = 30;
  localparam logic [11:0] TP  = 12'hA5B;
  localparam logic [11:0] SOF = 12'h9D0;
  localparam logic [11:0] SOL = 12'h800;
  localparam logic [11:0] EOL = 12'hAB0;
  localparam logic [11:0] EOF = 12'hB60;

  typedef logic [NUM_CH-1:0][WORD_W-1:0] lanes_t;
  typedef struct { int unsigned addr; int unsigned data; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NUM_CH-1:0] bit_in;
  logic              bit_valid;
  logic              relock;

  logic [ADDR_W-1:0]   m_addr;
  logic [OUT_W-1:0]    m_data;
  logic                m_we, m_locked, m_fs, m_le, m_err;
  logic [ADDR_W_S-1:0] s_addr;
  logic [OUT_W-1:0]    s_data;
  logic                s_we, s_locked, s_fs, s_le, s_err;

  lvds_sync_word_decoder #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
`ifdef LINE_LEN_CHECK_EN
    , .LINE_LEN(LINE_LEN_T)
`endif
  ) u_dut (
    .clk(clk), .io_rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .relock(relock),
    .address(m_addr), .data_word(m_data), .write_en(m_we), .locked(m_locked),
    .frame_start(m_fs), .line_end(m_le), .sync_err(m_err)
  );

  lvds_sync_word_decoder #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W_S)
`ifdef LINE_LEN_CHECK_EN
    , .LINE_LEN(LINE_LEN_T)
`endif
  ) u_dut_s (
    .clk(clk), .io_rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .relock(relock),
    .address(s_addr), .data_word(s_data), .write_en(s_we), .locked(s_locked),
    .frame_start(s_fs), .line_end(s_le), .sync_err(s_err)
  );

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0, le_cnt = 0, wr_cnt = 0;
  int exp_fs = 0, exp_le = 0;
  int unsigned m_ptr = 0, m_pix = 0;
  logic exp_err = 1'b0;
  wr_t q_main[$];
  wr_t q_s[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and pulse counters
  always @(negedge clk) begin
    wr_t e;
    if (m_we === 1'b1) begin
      wr_cnt++;
      if (q_main.size() == 0) check("main_unexpected_write", 32'(m_addr), 32'hFFFF_FFFF);
      else begin
        e = q_main.pop_front();
        check("main_addr", 32'(m_addr), e.addr);
        check("main_data", 32'(m_data), e.data);
      end
    end
    if (s_we === 1'b1) begin
      if (q_s.size() == 0) check("small_unexpected_write", 32'(s_addr), 32'hFFFF_FFFF);
      else begin
        e = q_s.pop_front();
        check("small_addr", 32'(s_addr), e.addr);
        check("small_data", 32'(s_data), e.data);
      end
    end
    if (m_fs === 1'b1) fs_cnt++;
    if (m_le === 1'b1) le_cnt++;
  end

  task automatic send_word(input lanes_t w);
    for (int b = 0; b < WORD_W; b++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); bit_valid = 1'b0;
      end
      @(negedge clk);
      bit_valid = 1'b1;
      for (int k = 0; k < NUM_CH; k++) bit_in[k] = w[k][b];
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_lane0(input logic [11:0] v);
    lanes_t w;
    for (int k = 0; k < NUM_CH; k++) w[k] = 12'($urandom);
    w[0] = v;
    send_word(w);
  endtask

  task automatic send_zero_words(input int n);
    lanes_t z;
    z = '0;
    for (int i = 0; i < n; i++) send_word(z);
  endtask

  task automatic send_sync(input logic [11:0] code);
    send_lane0(code);
    send_lane0(12'h000);
    send_lane0(12'h000);
    send_lane0(12'hFFF);
  endtask

  // Line start: address restarts; a start inside a line is an error
  task automatic start_line(input logic [11:0] code, input bit in_line);
    send_sync(code);
    m_ptr = 0;
    m_pix = 0;
    if (in_line) exp_err = 1'b1;
    else if (code == SOF) exp_fs++;
  endtask

  task automatic end_line(input logic [11:0] code);
    send_sync(code);
    exp_le++;
`ifdef LINE_LEN_CHECK_EN
    if (m_pix != LINE_LEN_T) exp_err = 1'b1;
`endif
  endtask

  // Every pixel of every lane is written, lane 0 first, at consecutive addresses
  task automatic send_pix(input int n, input bit ramp);
    lanes_t w;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        w[k] = ramp ? 12'((k << 8) | i) : 12'($urandom_range(1, 12'hFFE));
        q_main.push_back('{m_ptr % (1 << ADDR_W), 32'(w[k])});
        q_s.push_back('{m_ptr % (1 << ADDR_W_S), 32'(w[k])});
        m_ptr++;
      end
      m_pix++;
      send_word(w);
    end
  endtask

  task automatic lock_seq(input int n_ones);
    for (int i = 0; i < n_ones; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 4'($urandom);
      bit_in[0] = 1'b1;
    end
    for (int t = 1; t <= 5; t++) begin
      send_lane0(TP);
      if (t == 3) begin
        check("locked_after_3tp", 32'(m_locked), 0);
        check("small_locked_after_3tp", 32'(s_locked), 0);
      end
      if (t == 4) begin
        check("locked_after_4tp", 32'(m_locked), 1);
        check("small_locked_after_4tp", 32'(s_locked), 1);
      end
    end
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
  endtask

  task automatic check_line_done(input string tag);
    check({tag, "_main_pending"}, 32'(q_main.size()), 0);
    check({tag, "_small_pending"}, 32'(q_s.size()), 0);
    check({tag, "_sync_err"}, 32'(m_err), 32'(exp_err));
    check({tag, "_small_sync_err"}, 32'(s_err), 32'(exp_err));
    check({tag, "_frame_starts"}, 32'(fs_cnt), 32'(exp_fs));
    check({tag, "_line_ends"}, 32'(le_cnt), 32'(exp_le));
  endtask

  initial begin
    logic [11:0] code;
    rst_n = 1'b0; bit_in = '0; bit_valid = 1'b0; relock = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({m_addr, m_data, m_we, m_locked, m_fs, m_le, m_err}), 0);
    check("small_reset_outputs", 32'({s_addr, s_data, s_we, s_locked, s_fs, s_le, s_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lock on training pattern, no writes
    lock_seq(100);
    drain();
    check("no_write_while_locking", 32'(wr_cnt), 0);

    // Frame: SOF, ramp of 30 words per lane, EOL
    start_line(SOF, 1'b0);
    drain();
    check("frame_start_once", 32'(fs_cnt), 1);
    send_pix(30, 1'b1);
    end_line(EOL);
    drain();
    check("writes_120", 32'(wr_cnt), 120);
    check("addr_after_line", 32'(m_addr), 120);
    check("small_addr_after_line", 32'(s_addr), 120 % 16);
    check_line_done("frame");

    // Empty line: SOL then EOF
    start_line(SOL, 1'b0);
    check("empty_addr_reset", 32'(m_addr), 0);
    check("small_empty_addr_reset", 32'(s_addr), 0);
    end_line(EOF);
    drain();
    check("empty_no_write", 32'(wr_cnt), 120);
    check_line_done("empty");

    // 6 pixels x 4 lanes wrap the 4-bit address
    start_line(SOL, 1'b0);
    send_pix(6, 1'b0);
    end_line(EOL);
    drain();
    check_line_done("wrap");

    // Random lines with optional filler between them
    for (int r = 0; r < 6; r++) begin
      code = ($urandom_range(0, 1) == 0) ? SOF : SOL;
      if ($urandom_range(0, 1) == 0) send_lane0(TP);
      start_line(code, 1'b0);
      send_pix($urandom_range(0, 10), 1'b0);
      end_line(($urandom_range(0, 1) == 0) ? EOL : EOF);
      drain();
      check_line_done("random_line");
    end

    // SOL inside an active line
    start_line(SOL, 1'b0);
    send_pix(5, 1'b0);
    start_line(SOL, 1'b1);
    check("restart_addr", 32'(m_addr), 0);
    check("restart_sync_err", 32'(m_err), 1);
    send_pix(4, 1'b0);
    end_line(EOL);
    drain();
    check_line_done("restart");

    // RELOCK clears error and lock; nothing written while hunting
    @(negedge clk); relock = 1'b1;
    @(negedge clk); relock = 1'b0;
    exp_err = 1'b0;
    check("relock_locked", 32'(m_locked), 0);
    check("relock_sync_err", 32'(m_err), 0);
    send_zero_words(3);
    drain();
    check("hunt_stays_unlocked", 32'(m_locked), 0);
    lock_seq(20);
    start_line(SOL, 1'b0);
    send_pix(3, 1'b0);
    end_line(EOL);
    drain();
    check_line_done("after_relock");

`ifdef LINE_LEN_CHECK_EN
    @(negedge clk); relock = 1'b1;
    @(negedge clk); relock = 1'b0;
    exp_err = 1'b0;
    lock_seq(20);
    start_line(SOL, 1'b0);
    send_pix(30, 1'b0);
    end_line(EOL);
    drain();
    check("len30_sync_err", 32'(m_err), 0);
    start_line(SOL, 1'b0);
    send_pix(29, 1'b0);
    end_line(EOL);
    drain();
    check("len29_sync_err", 32'(m_err), 1);
    check_line_done("line_len");
`endif

    // Reset mid-line: pixels still inside the delay line are never written
    start_line(SOL, 1'b0);
    send_pix(5, 1'b0);
    for (int i = 0; i < 3 * NUM_CH; i++) begin
      void'(q_main.pop_back());
      void'(q_s.pop_back());
    end
    drain();
    rst_n = 1'b0;
    @(negedge clk);
    check("midline_reset_outputs", 32'({m_addr, m_data, m_we, m_locked, m_fs, m_le, m_err}), 0);
    rst_n = 1'b1;
    send_zero_words(3);
    drain();
    check("post_reset_unlocked", 32'(m_locked), 0);
    check("post_reset_main_pending", 32'(q_main.size()), 0);
    check("post_reset_small_pending", 32'(q_s.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
